oled_spi_sink: RTL

OLED_SPI_SINK -- requirements
Module: oled_spi_sink

---
 rtl/oled_spi_pkg.sv | 55 +++++
 rtl/spi_byte_rx.sv | 76 +++++++
 rtl/oled_spi_sink.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/oled_spi_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | oled_spi_pkg : geometry, opcodes and decode helpers for the sink |
// | Revision     : 1.0                                               |
// +------------------------------------------------------------------+
package oled_spi_pkg;

  localparam int PAGE_W   = 3;
  localparam int COL_W    = 7;
  localparam int FB_DEPTH = 1024;
  localparam int FB_AW    = PAGE_W + COL_W;

  localparam logic [7:0] C_CMD_DISP_OFF     = 8'hAE;
  localparam logic [7:0] C_CMD_DISP_ON      = 8'hAF;
  localparam logic [7:0] C_CMD_CONTRAST     = 8'h81;
  localparam logic [7:0] C_CMD_CHARGE_PUMP  = 8'h8D;
  localparam logic [7:0] C_CMD_MUX_RATIO    = 8'hA8;
  localparam logic [7:0] C_CMD_DISP_OFFSET  = 8'hD3;
  localparam logic [7:0] C_CMD_CLK_DIV      = 8'hD5;
  localparam logic [7:0] C_CMD_PRECHARGE    = 8'hD9;
  localparam logic [7:0] C_CMD_COM_PINS     = 8'hDA;
  localparam logic [7:0] C_CMD_VCOMH        = 8'hDB;
  localparam logic [7:0] C_CMD_ADDR_MODE    = 8'h20;
  localparam logic [7:0] C_CMD_COL_RANGE    = 8'h21;
  localparam logic [7:0] C_CMD_PAGE_RANGE   = 8'h22;
  localparam logic [7:0] C_CMD_COM_SCAN_INC = 8'hC0;
  localparam logic [7:0] C_CMD_COM_SCAN_DEC = 8'hC8;

  localparam logic [8:0][7:0] C_ARG1_OPS = {
    C_CMD_CONTRAST, C_CMD_CHARGE_PUMP, C_CMD_MUX_RATIO,
    C_CMD_DISP_OFFSET, C_CMD_CLK_DIV, C_CMD_PRECHARGE,
    C_CMD_COM_PINS, C_CMD_VCOMH, C_CMD_ADDR_MODE};
  localparam logic [1:0][7:0] C_ARG2_OPS = {C_CMD_COL_RANGE, C_CMD_PAGE_RANGE};

  typedef enum logic {ST_CMD = 1'b0, ST_ARG = 1'b1} dec_state_t;

  function automatic logic is_arg1(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 9; i++) if (b == C_ARG1_OPS[i]) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic is_arg2(input logic [7:0] b);
    return (b == C_ARG2_OPS[0]) || (b == C_ARG2_OPS[1]);
  endfunction

  // Opcodes accepted silently: start line, remap/inverse/entire-on, COM scan.
  function automatic logic is_nop(input logic [7:0] b);
    return (b[7:6] == 2'b01) || (b[7:3] == 5'b10100) ||
           (b == C_CMD_COM_SCAN_INC) || (b == C_CMD_COM_SCAN_DEC);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_byte_rx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_byte_rx : mode-0 SPI byte receiver with input synchronisers  |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module spi_byte_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sck,
  input  logic       i_sdin,
  input  logic       i_cs,
  input  logic       i_dc,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_byte_dc
);

  logic [1:0] r_sck_sync, r_sdin_sync, r_cs_sync, r_dc_sync;
  logic       r_sck_d, r_cs_d;
  logic [7:0] r_shift;
  logic [2:0] r_cnt;
  logic       r_valid, r_dc;
  logic [7:0] r_data;

  logic       w_sck_rise, w_cs_rise, w_take, w_last;
  logic [7:0] w_shift_in;

  assign w_sck_rise = r_sck_sync[1] & ~r_sck_d;
  assign w_cs_rise  = r_cs_sync[1] & ~r_cs_d;
  assign w_last     = (r_cnt == 3'd7);
  assign w_shift_in = {r_shift[6:0], r_sdin_sync[1]};
  // An 8th edge seen together with the cs release still completes the byte.
  assign w_take     = w_sck_rise & (~r_cs_sync[1] | (w_cs_rise & w_last));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sck_sync  <= 2'b00;
      r_sdin_sync <= 2'b00;
      r_cs_sync   <= 2'b11;
      r_dc_sync   <= 2'b00;
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b1;
      r_shift     <= 8'h00;
      r_cnt       <= 3'd0;
      r_valid     <= 1'b0;
      r_data      <= 8'h00;
      r_dc        <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[0], i_sck};
      r_sdin_sync <= {r_sdin_sync[0], i_sdin};
      r_cs_sync   <= {r_cs_sync[0], i_cs};
      r_dc_sync   <= {r_dc_sync[0], i_dc};
      r_sck_d     <= r_sck_sync[1];
      r_cs_d      <= r_cs_sync[1];
      r_valid     <= 1'b0;
      if (w_take) begin
        r_shift <= w_shift_in;
        r_cnt   <= r_cnt + 3'd1;
        if (w_last) begin
          r_valid <= 1'b1;
          r_data  <= w_shift_in;
          r_dc    <= r_dc_sync[1];
        end
      end else if (r_cs_sync[1]) begin
        r_cnt   <= 3'd0;
        r_shift <= 8'h00;
      end
    end
  end

  assign o_byte_valid = r_valid;
  assign o_byte_data  = r_data;
  assign o_byte_dc    = r_dc;

endmodule
`default_nettype wire

// File: rtl/oled_spi_sink.sv
`default_nettype none
// +------------------------------------------------------------------+
// | oled_spi_sink : OLED controller SPI sink, command decoder and    |
// |                 optional frame buffer (OLED_SPI_SINK_FB_EN)      |
// | Revision      : 1.0                                              |
// +------------------------------------------------------------------+
module oled_spi_sink
  import oled_spi_pkg::*;
(
  input  logic                   clkin_50m,
  input  logic                   sys_rst_n,
  input  logic                   sck,
  input  logic                   sdin,
  input  logic                   cs,
  input  logic                   dc,
  output logic                   byte_valid,
  output logic [7:0]             byte_data,
  output logic                   byte_dc,
  output logic                   fb_we,
  output logic [FB_AW-1:0]       fb_addr,
  output logic [7:0]             fb_wdata,
  output logic [PAGE_W-1:0]      cur_page,
  output logic [COL_W-1:0]       cur_col,
  output logic                   disp_on,
  output logic                   unk_cmd,
  input  logic [FB_AW-1:0]       rd_addr,
  output logic [7:0]             rd_data
);

  logic             w_bv, w_bdc;
  logic [7:0]       w_bdata;

  spi_byte_rx u_rx (
    .clk          (clkin_50m),
    .rst_n        (sys_rst_n),
    .i_sck        (sck),
    .i_sdin       (sdin),
    .i_cs         (cs),
    .i_dc         (dc),
    .o_byte_valid (w_bv),
    .o_byte_data  (w_bdata),
    .o_byte_dc    (w_bdc)
  );

  dec_state_t        r_state, w_state_nxt;
  logic [1:0]        r_arg_cnt, w_arg_nxt;
  logic [PAGE_W-1:0] r_page;
  logic [COL_W-1:0]  r_col;
  logic              r_disp, r_fb_we, r_unk;
  logic [FB_AW-1:0]  r_fb_addr;
  logic [7:0]        r_fb_wdata;

  logic w_write, w_col_lo, w_col_hi, w_set_page, w_disp_off, w_disp_on, w_unk;

  always_ff @(posedge clkin_50m) begin
    if (!sys_rst_n) begin
      r_state   <= ST_CMD;
      r_arg_cnt <= 2'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_arg_cnt <= w_arg_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arg_nxt   = r_arg_cnt;
    w_write     = 1'b0;
    w_col_lo    = 1'b0;
    w_col_hi    = 1'b0;
    w_set_page  = 1'b0;
    w_disp_off  = 1'b0;
    w_disp_on   = 1'b0;
    w_unk       = 1'b0;
    if (w_bv) begin
      case (r_state)
        ST_CMD: begin
          if (w_bdc)                           w_write    = 1'b1;
          else if (w_bdata[7:4] == 4'h0)       w_col_lo   = 1'b1;
          else if (w_bdata[7:3] == 5'b00010)   w_col_hi   = 1'b1;
          else if (w_bdata[7:3] == 5'b10110)   w_set_page = 1'b1;
          else if (w_bdata == C_CMD_DISP_OFF)  w_disp_off = 1'b1;
          else if (w_bdata == C_CMD_DISP_ON)   w_disp_on  = 1'b1;
          else if (is_arg1(w_bdata)) begin
            w_state_nxt = ST_ARG;
            w_arg_nxt   = 2'd1;
          end else if (is_arg2(w_bdata)) begin
            w_state_nxt = ST_ARG;
            w_arg_nxt   = 2'd2;
          end else if (!is_nop(w_bdata))       w_unk      = 1'b1;
        end
        ST_ARG: begin
          w_arg_nxt = r_arg_cnt - 2'd1;
          if (r_arg_cnt == 2'd1) w_state_nxt = ST_CMD;
        end
        default: w_state_nxt = ST_CMD;
      endcase
    end
  end

  always_ff @(posedge clkin_50m) begin
    if (!sys_rst_n) begin
      r_page     <= '0;
      r_col      <= '0;
      r_disp     <= 1'b0;
      r_fb_we    <= 1'b0;
      r_fb_addr  <= '0;
      r_fb_wdata <= 8'h00;
      r_unk      <= 1'b0;
    end else begin
      r_fb_we <= w_write;
      r_unk   <= w_unk;
      // Column wraps 127 -> 0 through natural 7-bit overflow; page is left alone.
      if (w_write) begin
        r_fb_addr  <= {r_page, r_col};
        r_fb_wdata <= w_bdata;
        r_col      <= r_col + 7'd1;
      end
      if (w_col_lo)   r_col[3:0] <= w_bdata[3:0];
      if (w_col_hi)   r_col[6:4] <= w_bdata[2:0];
      if (w_set_page) r_page     <= w_bdata[2:0];
      if (w_disp_off) r_disp     <= 1'b0;
      if (w_disp_on)  r_disp     <= 1'b1;
    end
  end

`ifdef OLED_SPI_SINK_FB_EN
  logic [7:0] r_mem [FB_DEPTH];
  logic [7:0] r_rd_data;

  always_ff @(posedge clkin_50m) begin
    if (r_fb_we) r_mem[r_fb_addr] <= r_fb_wdata;
    r_rd_data <= r_mem[rd_addr];
  end

  assign rd_data = r_rd_data;
`else
  logic w_unused_rd;
  assign w_unused_rd = ^rd_addr;
  assign rd_data     = 8'h00;
`endif

  assign byte_valid = w_bv;
  assign byte_data  = w_bdata;
  assign byte_dc    = w_bdc;
  assign fb_we      = r_fb_we;
  assign fb_addr    = r_fb_addr;
  assign fb_wdata   = r_fb_wdata;
  assign cur_page   = r_page;
  assign cur_col    = r_col;
  assign disp_on    = r_disp;
  assign unk_cmd    = r_unk;

endmodule
`default_nettype wire
